// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the pipeline front end.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned KERNEL_BIT = 31;

    // sll $0,$0,0 doubles as the pipeline bubble
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // Exception vectors selected by the IF next-PC mux
    localparam logic [XLEN-1:0] ILLOP = 32'h8000_0004;
    localparam logic [XLEN-1:0] XADR  = 32'h8000_0008;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } if_id_state_e;

    function automatic logic [XLEN-1:0] pc_plus_4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load-use hold, jump/branch flush and
// single-shot interrupt delivery followed by a one-cycle squash.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_Instruction,
    input  logic        Loaduse,
    input  logic        ID_Jump,
    input  logic        EX_Branch_EN,
    input  logic        irq_in,
    input  logic        irq_ack,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC_Plus_4,
    output logic [31:0] ID_Instruction,
    output logic        ID_Valid,
    output logic        ID_IRQ,
    output logic [31:0] ID_EPC
);

    if_id_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              irq_pending_q, irq_pending_d;
    logic              irq_take_c;
    logic              flush_c;

    // The controller's acknowledge only clears the request at its source
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;

    // Deliver only on a real, user-mode, right-path instruction outside the squash slot
    assign irq_take_c = irq_pending_q & valid_q & ~pc_q[KERNEL_BIT]
                      & ~EX_Branch_EN & (state_q == RUN);

    assign flush_c = (state_q == SQUASH) | irq_take_c | EX_Branch_EN | ID_Jump;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= '0;
            instr_q       <= NOP_INSTR;
            valid_q       <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    // Next-state: flush beats stall, stall beats load
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        valid_d       = valid_q;
        irq_pending_d = irq_pending_q;

        if (flush_c) begin
            pc_d    = IF_PC;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!Loaduse) begin
            pc_d    = IF_PC;
            instr_d = IF_Instruction;
            valid_d = 1'b1;
        end

        if (irq_take_c) begin
            irq_pending_d = 1'b0;
        end else if (irq_in && !IF_PC[KERNEL_BIT]) begin
            irq_pending_d = 1'b1;
        end

        unique case (state_q)
            RUN:    if (irq_take_c) state_d = SQUASH;
            SQUASH: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign ID_PC          = pc_q;
    assign ID_PC_Plus_4   = pc_plus_4(pc_q);
    assign ID_Instruction = instr_q;
    assign ID_Valid       = valid_q;
    assign ID_IRQ         = irq_take_c;
    assign ID_EPC         = pc_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios plus a randomized
// run against a cycle-level reference model of the IF/ID contract.
`timescale 1ns/1ps
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_PC, IF_Instruction;
    logic        Loaduse, ID_Jump, EX_Branch_EN, irq_in, irq_ack;
    logic [31:0] ID_PC, ID_PC_Plus_4, ID_Instruction, ID_EPC;
    logic        ID_Valid, ID_IRQ;

    int checks   = 0;
    int failures = 0;

    // Reference model: what ID holds, whether an IRQ is waiting, and
    // whether the previous cycle delivered an interrupt (squash slot).
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_pend, m_sq;

    wire [129:0] dut_out = {ID_PC, ID_PC_Plus_4, ID_Instruction, ID_Valid, ID_IRQ, ID_EPC};

    if_id_reg dut (
        .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_Instruction(IF_Instruction),
        .Loaduse(Loaduse), .ID_Jump(ID_Jump), .EX_Branch_EN(EX_Branch_EN),
        .irq_in(irq_in), .irq_ack(irq_ack), .ID_PC(ID_PC), .ID_PC_Plus_4(ID_PC_Plus_4),
        .ID_Instruction(ID_Instruction), .ID_Valid(ID_Valid), .ID_IRQ(ID_IRQ), .ID_EPC(ID_EPC)
    );

    always #5 clk = ~clk;

    function automatic logic exp_irq();
        return m_pend && m_valid && !m_pc[31] && !EX_Branch_EN && !m_sq;
    endfunction

    function automatic logic [129:0] model_out();
        return {m_pc, m_pc + 32'd4, m_instr, m_valid, exp_irq(), m_pc};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic cyc(input logic rst, input logic [31:0] pc, input logic [31:0] ins,
                       input logic lu, input logic j, input logic br,
                       input logic irq, input logic ack);
        logic take;
        @(negedge clk);
        reset = rst; IF_PC = pc; IF_Instruction = ins; Loaduse = lu;
        ID_Jump = j; EX_Branch_EN = br; irq_in = irq; irq_ack = ack;
        #1;
        take = exp_irq();
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_pend = 1'b0; m_sq = 1'b0;
        end else begin
            if (m_sq || take || br || j) begin
                m_pc = pc; m_instr = 32'h0; m_valid = 1'b0;
            end else if (!lu) begin
                m_pc = pc; m_instr = ins; m_valid = 1'b1;
            end
            if (take)                m_pend = 1'b0;
            else if (irq && !pc[31]) m_pend = 1'b1;
            m_sq = take;
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 32'h1234, 32'hDEAD_BEEF, 1, 0, 0, 1, 0);
        cyc(1, 32'h5678, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
        checks++;
        if (dut_out !== {32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset: got %h required %h", dut_out,
                     {32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0});
        end
    endtask

    task automatic test_stream();
        logic [31:0] ins [3] = '{32'h2008_0001, 32'h2009_0002, 32'h0109_5020};
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'(i * 4), ins[i], 0, 0, 0, 0, 0);
            checks++;
            if (ID_PC !== 32'(i * 4) || ID_PC_Plus_4 !== 32'(i * 4 + 4) ||
                ID_Instruction !== ins[i] || ID_Valid !== 1'b1) begin
                failures++;
                $display("FAIL stream[%0d]: got pc=%h pc4=%h ins=%h v=%b required pc=%h ins=%h v=1",
                         i, ID_PC, ID_PC_Plus_4, ID_Instruction, ID_Valid, 32'(i * 4), ins[i]);
            end
        end
    endtask

    task automatic test_loaduse();
        for (int i = 0; i < 2; i++) begin
            cyc(0, 32'hC, 32'h0000_1111, 1, 0, 0, 0, 0);
            checks++;
            if (ID_PC !== 32'h8 || ID_Instruction !== 32'h0109_5020 || ID_Valid !== 1'b1) begin
                failures++;
                $display("FAIL loaduse_hold[%0d]: got pc=%h ins=%h v=%b required pc=8 ins=01095020 v=1",
                         i, ID_PC, ID_Instruction, ID_Valid);
            end
        end
        cyc(0, 32'hC, 32'h0000_1111, 0, 0, 0, 0, 0);
        checks++;
        if (ID_PC !== 32'hC || ID_Instruction !== 32'h0000_1111) begin
            failures++;
            $display("FAIL loaduse_release: got pc=%h ins=%h required pc=c ins=00001111",
                     ID_PC, ID_Instruction);
        end
    endtask

    task automatic test_flush();
        cyc(0, 32'h10, 32'h0800_0040, 0, 1, 0, 0, 0);
        checks++;
        if (ID_Valid !== 1'b0 || ID_Instruction !== 32'h0 || ID_PC !== 32'h10) begin
            failures++;
            $display("FAIL jump_flush: got v=%b ins=%h pc=%h required v=0 ins=0 pc=10",
                     ID_Valid, ID_Instruction, ID_PC);
        end
        cyc(0, 32'h14, 32'h0000_2222, 0, 0, 0, 0, 0);
        cyc(0, 32'h18, 32'h0000_3333, 1, 0, 1, 0, 0);
        checks++;
        if (ID_Valid !== 1'b0 || ID_Instruction !== 32'h0 || ID_PC !== 32'h18) begin
            failures++;
            $display("FAIL branch_over_stall: got v=%b ins=%h pc=%h required v=0 ins=0 pc=18",
                     ID_Valid, ID_Instruction, ID_PC);
        end
        cyc(0, 32'hFFFF_FFFC, 32'h0000_4444, 0, 0, 0, 0, 0);
        checks++;
        if (ID_PC_Plus_4 !== 32'h0) begin
            failures++;
            $display("FAIL pc4_wrap: got %h required 00000000", ID_PC_Plus_4);
        end
    endtask

    task automatic test_irq_user();
        cyc(0, 32'h20, 32'h0000_5555, 0, 0, 0, 1, 0);
        checks++;
        if (ID_IRQ !== 1'b1 || ID_EPC !== 32'h20 || ID_PC !== 32'h20) begin
            failures++;
            $display("FAIL irq_deliver: got irq=%b epc=%h pc=%h required irq=1 epc=20 pc=20",
                     ID_IRQ, ID_EPC, ID_PC);
        end
        cyc(0, 32'h24, 32'h0000_6666, 0, 0, 0, 0, 1);
        checks++;
        if (ID_Valid !== 1'b0 || ID_IRQ !== 1'b0) begin
            failures++;
            $display("FAIL irq_squash: got v=%b irq=%b required v=0 irq=0", ID_Valid, ID_IRQ);
        end
        cyc(0, 32'h8000_0080, 32'h0000_7777, 0, 0, 0, 0, 0);
        cyc(0, 32'h0000_0084, 32'h0000_8888, 0, 0, 0, 0, 0);
        checks++;
        if (ID_Valid !== 1'b1 || ID_IRQ !== 1'b0) begin
            failures++;
            $display("FAIL irq_once: got v=%b irq=%b required v=1 irq=0", ID_Valid, ID_IRQ);
        end
    endtask

    task automatic test_irq_kernel();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'h8000_0040 + 32'(i * 4), 32'h0000_9999, 0, 0, 0, 1, 0);
            checks++;
            if (ID_IRQ !== 1'b0) begin
                failures++;
                $display("FAIL irq_kernel_mask[%0d]: got irq=%b required 0", i, ID_IRQ);
            end
        end
        cyc(0, 32'h0000_0100, 32'h0000_AAAA, 0, 0, 0, 1, 0);
        checks++;
        if (ID_IRQ !== 1'b1 || ID_EPC !== 32'h100) begin
            failures++;
            $display("FAIL irq_after_kernel: got irq=%b epc=%h required irq=1 epc=100",
                     ID_IRQ, ID_EPC);
        end
        cyc(0, 32'h0000_0104, 32'h0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_irq_branch();
        cyc(0, 32'h0000_01F0, 32'h0000_BBBB, 0, 0, 0, 0, 0);
        cyc(0, 32'h0000_0200, 32'h0000_CCCC, 0, 0, 0, 1, 0);
        EX_Branch_EN = 1'b1;
        irq_in = 1'b0;
        #1;
        checks++;
        if (ID_IRQ !== 1'b0) begin
            failures++;
            $display("FAIL irq_blocked_by_branch: got irq=%b required 0", ID_IRQ);
        end
        cyc(0, 32'h0000_0204, 32'h0000_DDDD, 0, 0, 1, 0, 0);
        cyc(0, 32'h0000_0400, 32'h0000_EEEE, 0, 0, 0, 0, 0);
        checks++;
        if (ID_IRQ !== 1'b1 || ID_EPC !== 32'h400 || ID_Valid !== 1'b1) begin
            failures++;
            $display("FAIL irq_on_target: got irq=%b epc=%h v=%b required irq=1 epc=400 v=1",
                     ID_IRQ, ID_EPC, ID_Valid);
        end
        cyc(0, 32'h0000_0404, 32'h0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_in_squash();
        cyc(0, 32'h0000_0300, 32'h0000_1234, 0, 0, 0, 1, 0);
        cyc(1, 32'h0000_0304, 32'h0000_5678, 1, 0, 0, 0, 0);
        cyc(0, 32'h0000_0308, 32'h0000_9ABC, 0, 0, 0, 0, 0);
        checks++;
        if (ID_Valid !== 1'b1 || ID_IRQ !== 1'b0 || ID_PC !== 32'h308) begin
            failures++;
            $display("FAIL reset_in_squash: got v=%b irq=%b pc=%h required v=1 irq=0 pc=308",
                     ID_Valid, ID_IRQ, ID_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            pc = ($urandom_range(0, 9) == 0) ? {1'b1, pc[30:0]} :
                 ($urandom_range(0, 9) == 0) ? (pc & 32'h7FFF_FFFC) : pc + 32'd4;
            cyc(0, pc, $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0), 1'b0);
            checks++;
            if (dut_out !== model_out()) begin
                failures++;
                $display("FAIL random[%0d]: got %h required %h", i, dut_out, model_out());
            end
        end
    endtask

    initial begin
        reset = 1'b1; IF_PC = '0; IF_Instruction = '0; Loaduse = 1'b0;
        ID_Jump = 1'b0; EX_Branch_EN = 1'b0; irq_in = 1'b0; irq_ack = 1'b0;
        m_pc = '0; m_instr = '0; m_valid = 1'b0; m_pend = 1'b0; m_sq = 1'b0;
        test_reset();
        test_stream();
        test_loaduse();
        test_flush();
        test_irq_user();
        test_irq_kernel();
        test_irq_branch();
        test_reset_in_squash();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
